// File: rtl/runtime_stat_unit.sv
// runtime_stat_unit: times runs from instr_en/synch, keeps last/min/max/total/count of final counts
// and buffers each result in a show-ahead history FIFO drained via valid/ready.
module runtime_stat_unit #(
  parameter int WORD_WIDTH  = 32,
  parameter int TOTAL_WIDTH = 48,
  parameter int DEPTH       = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_en,
  input  logic                   synch,
  input  logic [WORD_WIDTH-1:0]  ctr_val,
  input  logic                   clear,
  output logic                   running,
  output logic [WORD_WIDTH-1:0]  last_rt,
  output logic [WORD_WIDTH-1:0]  min_rt,
  output logic [WORD_WIDTH-1:0]  max_rt,
  output logic [TOTAL_WIDTH-1:0] total_rt,
  output logic [CNT_WIDTH-1:0]   run_cnt,
  output logic                   hist_valid,
  output logic [WORD_WIDTH-1:0]  hist_data,
  input  logic                   hist_ready,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
  logic [TOTAL_WIDTH-1:0] total_q, total_d;
  logic [TOTAL_WIDTH:0] sum;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] occ_q, occ_d;
  logic ovf_q, ovf_d;
  logic capture, full, pop, push;
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (instr_en && !synch) ? RUN : IDLE;
      RUN:     state_d = synch ? CAPTURE : RUN;
      default: state_d = IDLE;
    endcase
    capture = state_q == CAPTURE;
    full    = occ_q == FULL;
    pop     = hist_valid && hist_ready;
    // a full FIFO still accepts the new result when the head leaves in the same cycle
    push    = capture && (!full || pop);
    sum     = {1'b0, total_q} + (TOTAL_WIDTH+1)'(ctr_val);
    last_d  = capture ? ctr_val : last_q;
    min_d   = (capture && ctr_val < min_q) ? ctr_val : min_q;
    max_d   = (capture && ctr_val > max_q) ? ctr_val : max_q;
    total_d = !capture ? total_q : sum[TOTAL_WIDTH] ? '1 : sum[TOTAL_WIDTH-1:0];
    cnt_d   = (capture && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    occ_d   = (push && !pop) ? occ_q + 1'b1 : (!push && pop) ? occ_q - 1'b1 : occ_q;
    ovf_d   = ovf_q || (capture && !push);
    if (clear) begin
      state_d = IDLE;
      last_d  = '0;
      min_d   = '1;
      max_d   = '0;
      total_d = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      occ_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      min_q   <= '1;
      max_q   <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
    end
  end

  // storage needs no reset: occupancy gates everything read out of it
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_q] <= ctr_val;
  end

  assign running    = state_q == RUN;
  assign last_rt    = last_q;
  assign min_rt     = min_q;
  assign max_rt     = max_q;
  assign total_rt   = total_q;
  assign run_cnt    = cnt_q;
  assign overflow   = ovf_q;
  assign hist_valid = occ_q != '0;
  assign hist_data  = hist_valid ? mem[rd_q] : '0;
endmodule
